binop_sequencer: RTL and testbench
==================================

// Module: binop_sequencer
// PURPOSE
//  Sequences one WebAssembly numeric instruction (i32/i64 compare, arithmetic, eqz) over the shared
//  operand stack and ALU: pops operands, issues the ALU op, pushes the result, raises traps.
//  Sits between the cpu decode stage and the stack/ALU datapath; decode pulses start, waits for done.
// PARAMETERS
//  ALU_TIMEOUT   16   max cycles waiting for alu_done before TRAP_ALU_TIMEOUT
// PORTS
//  clk              in   1   clock, rising edge
//  reset            in   1   asynchronous, active-high; clears all state
//  start            in   1   one-cycle request; accepted only when busy==0
//  opcode           in   8   wasm opcode, sampled on accepted start
//  busy             out  1   high from accepted start until done/trap cycle inclusive
//  done             out  1   one-cycle pulse: result pushed
//  trap             out  3   sticky trap code, 0 = none; cleared by trap_clear or reset
//  trap_clear       in   1   clears trap, returns FSM to IDLE
//  stack_top        in  64   current top-of-stack value (combinational from stack)
//  stack_empty      in   1   stack holds zero entries
//  stack_full       in   1   stack has no free entry
//  stack_pop        out  1   pop strobe; top removed at clock edge
//  stack_push       out  1   push strobe
//  stack_push_data  out 64   value pushed with stack_push
//  alu_start        out  1   one-cycle pulse, operands/op valid
//  alu_op           out  8   opcode forwarded to ALU
//  alu_a, alu_b     out 64   operands (a = deeper, b = top); held stable until alu_done
//  alu_done         in   1   ALU result valid; earliest one cycle after alu_start
//  alu_result       in  64   ALU result
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0 (busy, done, trap, strobes, alu_a/b, push_data).
//  States: IDLE -> POP_B -> [POP_A] -> EXEC -> WAIT -> PUSH -> IDLE; any -> TRAP.
//  IDLE: start&&!busy latches opcode, -> POP_B. start while busy or in TRAP: ignored.
//  POP_B: stack_empty -> TRAP(UNDERFLOW); else alu_b<=stack_top, stack_pop=1; unary (0x45,0x50)
//    -> EXEC, binary -> POP_A.
//  POP_A: same rule, alu_a<=stack_top. Unary: alu_a=0.
//  Unknown opcode detected in IDLE->POP_B cycle -> TRAP(ILLEGAL) without popping.
//  EXEC: alu_start=1 one cycle -> WAIT. WAIT: counter from 0; alu_done -> latch result, -> PUSH;
//    counter==ALU_TIMEOUT-1 without done -> TRAP(ALU_TIMEOUT).
//  PUSH: stack_full -> TRAP(OVERFLOW) (never full after >=1 pop; defensive); else stack_push=1,
//    done=1 same cycle, -> IDLE.
//  Min latency start->done: 5 cycles (binary, alu_done one cycle after alu_start); unary 4.
//  Width: i32 ops (0x45-0x4F, 0x67-0x78) mask operands to [31:0]; all compares (0x45-0x5A) and
//    i32 ops push {32'b0, alu_result[31:0]}; i64 arithmetic (0x79-0x8A) pushes full 64 bits.
//  TRAP: busy=0, no strobes, trap held; trap_clear -> trap=0, IDLE next cycle. Stack not restored.
//  Reset mid-operation: immediate return to IDLE; popped operands lost; no spurious push/done.
// STRUCTURE
//  Package binop_pkg: state enum, TRAP_NONE=0, TRAP_UNDERFLOW=1, TRAP_OVERFLOW=2,
//    TRAP_ILLEGAL=3, TRAP_ALU_TIMEOUT=4; opcode constants and range helpers (is_unary, is_i32,
//    is_compare, is_valid).
//  Sub-module binop_decode: combinational opcode classifier (valid/unary/i32/compare flags).
// TESTING
//  Stack [1,1], start op 0x52 (i64.ne), ALU done +1 -> alu_a=1,alu_b=1, push 0, done at cycle 5.
//  Stack [1,2], 0x52 -> push 64'h1; stack_pop asserted exactly twice, push once.
//  Stack [64'hFFFF_FFFF_0000_0005], op 0x45 (i32.eqz) -> alu_b=5 masked, push 0, done at cycle 4.
//  Stack with one entry, 0x52 -> one pop, trap=1, no push; trap_clear -> trap=0, busy=0.
//  Opcode 0xFF -> trap=3, no pop; alu_done withheld 16 cycles -> trap=4.
//  Reset asserted in WAIT -> all outputs 0 next edge, no push; new start then completes normally.

Source files
------------

// File: rtl/binop_pkg.sv
// binop_pkg
//   Shared definitions for the numeric-instruction sequencer: FSM state
//   encoding, trap codes, opcode range constants and opcode classifier
//   helpers used by binop_decode.
package binop_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP_B = 3'd1,
        ST_POP_A = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_PUSH  = 3'd5,
        ST_TRAP  = 3'd6
    } state_t;

    localparam logic [2:0] TRAP_NONE        = 3'd0;
    localparam logic [2:0] TRAP_UNDERFLOW   = 3'd1;
    localparam logic [2:0] TRAP_OVERFLOW    = 3'd2;
    localparam logic [2:0] TRAP_ILLEGAL     = 3'd3;
    localparam logic [2:0] TRAP_ALU_TIMEOUT = 3'd4;

    localparam logic [7:0] OP_I32_EQZ    = 8'h45;
    localparam logic [7:0] OP_I64_EQZ    = 8'h50;
    localparam logic [7:0] OP_I32_CMP_HI = 8'h4F;  // last i32 compare
    localparam logic [7:0] OP_CMP_LO     = 8'h45;
    localparam logic [7:0] OP_CMP_HI     = 8'h5A;
    localparam logic [7:0] OP_I32_LO     = 8'h67;
    localparam logic [7:0] OP_I32_HI     = 8'h78;
    localparam logic [7:0] OP_I64_LO     = 8'h79;
    localparam logic [7:0] OP_I64_HI     = 8'h8A;

    function automatic logic is_unary(input logic [7:0] op);
        return (op == OP_I32_EQZ) || (op == OP_I64_EQZ);
    endfunction

    function automatic logic is_i32(input logic [7:0] op);
        return ((op >= OP_CMP_LO) && (op <= OP_I32_CMP_HI)) ||
               ((op >= OP_I32_LO) && (op <= OP_I32_HI));
    endfunction

    function automatic logic is_compare(input logic [7:0] op);
        return (op >= OP_CMP_LO) && (op <= OP_CMP_HI);
    endfunction

    function automatic logic is_valid(input logic [7:0] op);
        return is_compare(op) || ((op >= OP_I32_LO) && (op <= OP_I64_HI));
    endfunction

endpackage

// File: rtl/binop_decode.sv
// binop_decode
//   Combinational opcode classifier.
//   opcode  : wasm opcode under decode
//   valid   : opcode is a supported compare/arithmetic instruction
//   unary   : instruction takes a single stack operand (eqz forms)
//   i32     : 32-bit instruction, operands are masked to [31:0]
//   compare : compare instruction, result is a 32-bit boolean
module binop_decode
    import binop_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       valid,
    output logic       unary,
    output logic       i32,
    output logic       compare
);

    assign valid   = is_valid(opcode);
    assign unary   = is_unary(opcode);
    assign i32     = is_i32(opcode);
    assign compare = is_compare(opcode);

endmodule

// File: rtl/binop_sequencer.sv
// binop_sequencer
//   Runs one wasm numeric instruction over the shared operand stack and ALU:
//   pops one or two operands, starts the ALU, waits for its result, pushes
//   the (width-adjusted) result, and records a sticky trap code on failure.
//   clk, reset                 : clock, asynchronous active-high reset
//   start, opcode, busy, done  : request handshake with the decode stage
//   trap, trap_clear           : sticky trap code and its clear strobe
//   stack_top/empty/full       : stack status (stack_top is combinational)
//   stack_pop/push/push_data   : stack strobes, effective at the clock edge
//   alu_start/op/a/b           : ALU request; a = deeper operand, b = top
//   alu_done, alu_result       : ALU response
module binop_sequencer
    import binop_pkg::*;
#(
    parameter int ALU_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        opcode,
    output logic              busy,
    output logic              done,
    output logic [2:0]        trap,
    input  logic              trap_clear,
    input  logic [DATA_W-1:0] stack_top,
    input  logic              stack_empty,
    input  logic              stack_full,
    output logic              stack_pop,
    output logic              stack_push,
    output logic [DATA_W-1:0] stack_push_data,
    output logic              alu_start,
    output logic [7:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result
);

    localparam int CNT_W = $clog2(ALU_TIMEOUT) + 1;

    state_t              state_reg;
    logic [7:0]          op_reg;
    logic [DATA_W-1:0]   alu_a_reg;
    logic [DATA_W-1:0]   alu_b_reg;
    logic [DATA_W-1:0]   push_data_reg;
    logic [2:0]          trap_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;

    logic                dec_valid;
    logic                dec_unary;
    logic                dec_i32;
    logic                dec_compare;
    logic [DATA_W-1:0]   operand_in;
    logic [DATA_W-1:0]   push_value;

    // Classify the latched opcode so decisions in POP_B onwards are stable
    // even if the decode stage changes opcode after the accepting cycle.
    binop_decode u_decode (
        .opcode  (op_reg),
        .valid   (dec_valid),
        .unary   (dec_unary),
        .i32     (dec_i32),
        .compare (dec_compare)
    );

    assign operand_in = dec_i32 ? {32'b0, stack_top[31:0]} : stack_top;
    assign push_value = (dec_i32 || dec_compare) ? {32'b0, alu_result[31:0]}
                                                 : alu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            push_data_reg <= '0;
            trap_reg      <= TRAP_NONE;
            wait_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg    <= opcode;
                        alu_a_reg <= '0;   // stays 0 for unary ops
                        alu_b_reg <= '0;
                        state_reg <= ST_POP_B;
                    end
                end
                ST_POP_B: begin
                    // Illegal opcodes trap before anything leaves the stack.
                    if (!dec_valid) begin
                        trap_reg  <= TRAP_ILLEGAL;
                        state_reg <= ST_TRAP;
                    end else if (stack_empty) begin
                        trap_reg  <= TRAP_UNDERFLOW;
                        state_reg <= ST_TRAP;
                    end else begin
                        alu_b_reg <= operand_in;
                        state_reg <= dec_unary ? ST_EXEC : ST_POP_A;
                    end
                end
                ST_POP_A: begin
                    if (stack_empty) begin
                        trap_reg  <= TRAP_UNDERFLOW;
                        state_reg <= ST_TRAP;
                    end else begin
                        alu_a_reg <= operand_in;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result arriving on the last allowed cycle still wins.
                    if (alu_done) begin
                        push_data_reg <= push_value;
                        state_reg     <= ST_PUSH;
                    end else if (wait_cnt_reg == CNT_W'(ALU_TIMEOUT - 1)) begin
                        trap_reg  <= TRAP_ALU_TIMEOUT;
                        state_reg <= ST_TRAP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_PUSH: begin
                    // Cannot be full after a pop unless the stack misbehaves.
                    if (stack_full) begin
                        trap_reg  <= TRAP_OVERFLOW;
                        state_reg <= ST_TRAP;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_TRAP: begin
                    if (trap_clear) begin
                        trap_reg  <= TRAP_NONE;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Pop/push strobes must coincide with the cycle in which stack_top is
    // captured (or the push is committed), so they are decoded from the
    // registered state and the same-cycle stack status.
    assign stack_pop  = ((state_reg == ST_POP_B) && dec_valid && !stack_empty) ||
                        ((state_reg == ST_POP_A) && !stack_empty);
    assign stack_push = (state_reg == ST_PUSH) && !stack_full;
    assign done       = stack_push;
    assign alu_start  = (state_reg == ST_EXEC);
    assign busy       = (state_reg != ST_IDLE) && (state_reg != ST_TRAP);

    assign trap            = trap_reg;
    assign alu_op          = op_reg;
    assign alu_a           = alu_a_reg;
    assign alu_b           = alu_b_reg;
    assign stack_push_data = push_data_reg;

endmodule

// File: tb/tb_binop_sequencer.sv
// tb_binop_sequencer
//   Directed bench for binop_sequencer. A behavioural stack and ALU sit
//   around the DUT; expected pushes and ALU operands are queued by the
//   stimulus and checked by a monitor when the DUT strobes them.
module tb_binop_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  opcode;
    logic        busy;
    logic        done;
    logic [2:0]  trap;
    logic        trap_clear;
    logic [63:0] stack_top;
    logic        stack_empty;
    logic        stack_full;
    logic        stack_pop;
    logic        stack_push;
    logic [63:0] stack_push_data;
    logic        alu_start;
    logic [7:0]  alu_op;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic        alu_done;
    logic [63:0] alu_result;

    binop_sequencer #(.ALU_TIMEOUT(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .opcode          (opcode),
        .busy            (busy),
        .done            (done),
        .trap            (trap),
        .trap_clear      (trap_clear),
        .stack_top       (stack_top),
        .stack_empty     (stack_empty),
        .stack_full      (stack_full),
        .stack_pop       (stack_pop),
        .stack_push      (stack_push),
        .stack_push_data (stack_push_data),
        .alu_start       (alu_start),
        .alu_op          (alu_op),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_done        (alu_done),
        .alu_result      (alu_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // ---------------- stack model ----------------
    logic [63:0] stk[$];
    bit          force_full = 0;
    bit          pop_pend   = 0;
    bit          push_pend  = 0;
    logic [63:0] push_val;
    int          pop_cnt  = 0;
    int          push_cnt = 0;

    task automatic refresh();
        stack_top   = (stk.size() > 0) ? stk[stk.size()-1] : 64'd0;
        stack_empty = (stk.size() == 0);
        stack_full  = (stk.size() >= DEPTH) || force_full;
    endtask

    task automatic set_stack2(input logic [63:0] deeper, input logic [63:0] top);
        stk.delete();
        stk.push_back(deeper);
        stk.push_back(top);
        refresh();
    endtask

    task automatic set_stack1(input logic [63:0] top);
        stk.delete();
        stk.push_back(top);
        refresh();
    endtask

    // Strobes are sampled at the negedge and committed just after the edge.
    always @(posedge clk) begin
        #1;
        if (pop_pend && stk.size() > 0) void'(stk.pop_back());
        if (push_pend) stk.push_back(push_val);
        pop_pend  = 0;
        push_pend = 0;
        refresh();
    end

    // ---------------- ALU model ----------------
    int          alu_delay = 1;   // 0 = never answer
    int          alu_cnt   = 0;
    logic [7:0]  cap_op;
    logic [63:0] cap_a, cap_b;

    function automatic logic [63:0] alu_model(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            8'h52:   return {63'd0, a != b};
            8'h45:   return {32'hDEADBEEF, 31'd0, b[31:0] == 32'd0};
            8'h6A:   return {32'hDEADBEEF, a[31:0] + b[31:0]};
            8'h7C:   return a + b;
            default: return 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    logic [63:0] exp_push[$];
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];

    always @(negedge clk) begin
        alu_done = 1'b0;
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_done   = 1'b1;
                alu_result = alu_model(cap_op, cap_a, cap_b);
            end
        end
        if (alu_start) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_alu_start: got alu_start=1 required 0");
            end else begin
                chk("alu_a", alu_a, exp_a.pop_front());
                chk("alu_b", alu_b, exp_b.pop_front());
            end
            alu_cnt = alu_delay;
            cap_op  = alu_op;
            cap_a   = alu_a;
            cap_b   = alu_b;
        end
        if (stack_pop) begin
            pop_pend = 1;
            pop_cnt++;
        end
        if (stack_push) begin
            push_pend = 1;
            push_val  = stack_push_data;
            push_cnt++;
            $display("txn op=%h a=%h b=%h push=%h", alu_op, alu_a, alu_b, stack_push_data);
            chk("done_with_push", done, 1);
            if (exp_push.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_push: got %h required no push", stack_push_data);
            end else begin
                chk("push_data", stack_push_data, exp_push.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input string name, input logic [7:0] op, input int exp_lat,
                          input int exp_pops, input int exp_pushes, input logic [2:0] exp_trap,
                          input bit restart);
        int cyc;
        bit seen;
        pop_cnt  = 0;
        push_cnt = 0;
        seen     = 0;
        @(negedge clk);
        start  = 1;
        opcode = op;
        for (cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 0;
            if (restart && cyc == 2) begin start = 1; opcode = 8'hFF; end
            if (restart && cyc == 3) start = 0;
            if (done || trap != 3'd0) begin
                seen = 1;
                break;
            end
        end
        start = 0;
        chk({name, " finished"}, 64'(seen), 1);
        chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
        @(negedge clk);
        chk({name, " pops"}, 64'(pop_cnt), 64'(exp_pops));
        chk({name, " pushes"}, 64'(push_cnt), 64'(exp_pushes));
        chk({name, " trap"}, 64'(trap), 64'(exp_trap));
        chk({name, " busy_after"}, 64'(busy), 0);
        $display("txn %s op=%h trap=%0d pops=%0d pushes=%0d", name, op, trap, pop_cnt, push_cnt);
    endtask

    task automatic do_trap_clear(input string name);
        @(negedge clk);
        trap_clear = 1;
        @(negedge clk);
        trap_clear = 0;
        chk({name, " trap_cleared"}, 64'(trap), 0);
        chk({name, " busy_cleared"}, 64'(busy), 0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, " busy"}, 64'(busy), 0);
        chk({name, " done"}, 64'(done), 0);
        chk({name, " trap"}, 64'(trap), 0);
        chk({name, " pop"}, 64'(stack_pop), 0);
        chk({name, " push"}, 64'(stack_push), 0);
        chk({name, " alu_start"}, 64'(alu_start), 0);
        chk({name, " alu_a"}, alu_a, 0);
        chk({name, " alu_b"}, alu_b, 0);
        chk({name, " push_data"}, stack_push_data, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1;
        start      = 0;
        opcode     = 8'h00;
        trap_clear = 0;
        alu_done   = 0;
        alu_result = 64'd0;
        refresh();
        repeat (3) @(negedge clk);
        chk_outputs_zero("in_reset");
        reset = 0;
        @(negedge clk);
        chk_outputs_zero("after_reset");

        // i64.ne on equal operands
        set_stack2(64'd1, 64'd1);
        exp_a.push_back(64'd1); exp_b.push_back(64'd1); exp_push.push_back(64'd0);
        run_op("ne_equal", 8'h52, 5, 2, 1, 3'd0, 0);

        // i64.ne on differing operands, with a start pulse while busy
        set_stack2(64'd1, 64'd2);
        exp_a.push_back(64'd1); exp_b.push_back(64'd2); exp_push.push_back(64'd1);
        run_op("ne_diff_restart", 8'h52, 5, 2, 1, 3'd0, 1);

        // i32.eqz: upper operand bits masked, upper result bits dropped
        set_stack1(64'hFFFF_FFFF_0000_0005);
        exp_a.push_back(64'd0); exp_b.push_back(64'd5); exp_push.push_back(64'd0);
        run_op("i32_eqz", 8'h45, 4, 1, 1, 3'd0, 0);

        // i64.add: full 64-bit result pushed
        set_stack2(64'h0000_0001_0000_0000, 64'h0000_0002_0000_0003);
        exp_a.push_back(64'h0000_0001_0000_0000); exp_b.push_back(64'h0000_0002_0000_0003);
        exp_push.push_back(64'h0000_0003_0000_0003);
        run_op("i64_add", 8'h7C, 5, 2, 1, 3'd0, 0);

        // i32.add: operands masked, wraps to 1, upper result bits dropped
        set_stack2(64'hAAAA_0000_FFFF_FFFF, 64'h5555_0000_0000_0002);
        exp_a.push_back(64'h0000_0000_FFFF_FFFF); exp_b.push_back(64'd2);
        exp_push.push_back(64'd1);
        run_op("i32_add", 8'h6A, 5, 2, 1, 3'd0, 0);

        // ALU answering on the last allowed wait cycle still completes
        alu_delay = 16;
        set_stack2(64'd10, 64'd11);
        exp_a.push_back(64'd10); exp_b.push_back(64'd11); exp_push.push_back(64'd1);
        run_op("alu_late_ok", 8'h52, 20, 2, 1, 3'd0, 0);
        alu_delay = 1;

        // Underflow with one entry, then start ignored while trapped
        set_stack1(64'd9);
        run_op("underflow", 8'h52, 3, 1, 0, 3'd1, 0);
        set_stack2(64'd1, 64'd2);
        pop_cnt = 0;
        @(negedge clk); start = 1; opcode = 8'h52;
        @(negedge clk); start = 0;
        repeat (3) @(negedge clk);
        chk("start_in_trap pops", 64'(pop_cnt), 0);
        chk("start_in_trap trap", 64'(trap), 1);
        do_trap_clear("underflow");

        // Illegal opcode: no pop even with operands available
        set_stack2(64'd1, 64'd2);
        run_op("illegal", 8'hFF, 2, 0, 0, 3'd3, 0);
        do_trap_clear("illegal");

        // ALU never answers
        alu_delay = 0;
        set_stack2(64'd3, 64'd4);
        exp_a.push_back(64'd3); exp_b.push_back(64'd4);
        run_op("alu_timeout", 8'h52, 20, 2, 0, 3'd4, 0);
        do_trap_clear("alu_timeout");
        alu_delay = 1;

        // Stack reporting full at push time
        force_full = 1;
        set_stack2(64'd5, 64'd6);
        exp_a.push_back(64'd5); exp_b.push_back(64'd6);
        run_op("overflow", 8'h52, 6, 2, 0, 3'd2, 0);
        force_full = 0;
        refresh();
        do_trap_clear("overflow");

        // Reset while waiting on the ALU
        alu_delay = 0;
        set_stack2(64'd7, 64'd9);
        exp_a.push_back(64'd7); exp_b.push_back(64'd9);
        push_cnt = 0;
        @(negedge clk); start = 1; opcode = 8'h52;
        @(negedge clk); start = 0;
        repeat (3) @(negedge clk);
        chk("in_wait busy", 64'(busy), 1);
        reset = 1;
        @(negedge clk);
        chk_outputs_zero("mid_reset");
        alu_cnt   = 0;
        alu_delay = 1;
        reset     = 0;
        @(negedge clk);
        chk("mid_reset pushes", 64'(push_cnt), 0);

        // Normal operation after the mid-operation reset
        set_stack2(64'h20, 64'h30);
        exp_a.push_back(64'h20); exp_b.push_back(64'h30); exp_push.push_back(64'h50);
        run_op("after_reset_add", 8'h7C, 5, 2, 1, 3'd0, 0);

        chk("exp_push drained", 64'(exp_push.size()), 0);
        chk("exp_alu drained", 64'(exp_a.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
